// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the register-file dumper.
//   REG_COUNT / REG_ADDR_W / REG_DATA_W : register-file geometry
//   dumper_state_e                      : dumper FSM state encoding
package mips_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dumper_state_e;

endpackage : mips_pkg

// File: rtl/mips_regfile_dumper_if.sv
// Valid/ready beat stream carrying one dumped register per beat.
//   dump_valid : beat fields are valid           (master -> slave)
//   dump_ready : sink accepts when valid&&ready  (slave -> master)
//   dump_data  : register contents               (master -> slave)
//   dump_index : register index of dump_data     (master -> slave)
//   dump_last  : final beat of the range         (master -> slave)
interface mips_regfile_dumper_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_index;
    logic              dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_index,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_index,
        input  dump_last,
        output dump_ready
    );

endinterface : mips_regfile_dumper_if

// File: rtl/mips_regfile_dumper.sv
// Walks register indices [first_reg..last_reg] through one register-file read
// port and streams each word out on a valid/ready interface.
//   clock, reset          : single clock, synchronous active-high reset
//   start                 : one-cycle request, sampled only in IDLE
//   first_reg, last_reg   : inclusive index range, latched on accepted start
//   rd_reg / rd_data      : register-file read port (combinational read)
//   dump                  : beat stream (master side)
//   busy                  : high from accepted start until the end of DONE
//   done, range_err       : one-cycle completion pulse / empty-range flag
module mips_regfile_dumper
    import mips_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     first_reg,
    input  logic [ADDR_W-1:0]     last_reg,
    output logic [ADDR_W-1:0]     rd_reg,
    input  logic [DATA_W-1:0]     rd_data,
    mips_regfile_dumper_if.master dump,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err
);

    dumper_state_e     state_q, state_d;
    logic [ADDR_W-1:0] rd_reg_q, rd_reg_d;
    logic [ADDR_W-1:0] range_last_q, range_last_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    always_comb begin
        state_d      = state_q;
        rd_reg_d     = rd_reg_q;
        range_last_d = range_last_q;
        valid_d      = valid_q;
        data_d       = data_q;
        index_d      = index_q;
        last_d       = last_q;
        busy_d       = busy_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (first_reg <= last_reg) begin
                        range_last_d = last_reg;
                        rd_reg_d     = first_reg;
                        err_d        = 1'b0;
                        state_d      = ST_LOAD;
                    end else begin
                        // Empty range: no beats, flag it alongside done.
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                data_d   = rd_data;
                index_d  = rd_reg_q;
                last_d   = (rd_reg_q == range_last_q);
                valid_d  = 1'b1;
                rd_reg_d = rd_reg_q + 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (valid_q && dump.dump_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        // Capture the next word on the accepting edge so
                        // back-to-back beats have no bubble.
                        data_d   = rd_data;
                        index_d  = rd_reg_q;
                        last_d   = (rd_reg_q == range_last_q);
                        rd_reg_d = rd_reg_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rd_reg_q     <= '0;
            range_last_q <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            index_q      <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_reg_q     <= rd_reg_d;
            range_last_q <= range_last_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            index_q      <= index_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign rd_reg          = rd_reg_q;
    assign dump.dump_valid = valid_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_index = index_q;
    assign dump.dump_last  = last_q;
    assign busy            = busy_q;
    assign done            = (state_q == ST_DONE);
    assign range_err       = (state_q == ST_DONE) && err_q;

endmodule : mips_regfile_dumper
